// File: rtl/game_ctl_pkg.sv
// game_ctl_pkg: shared phase encoding, screen geometry and default button rectangle.
package game_ctl_pkg;
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } state_e;
  localparam int SCREEN_W   = 800;
  localparam int SCREEN_H   = 600;
  localparam int DEF_BTN_X0 = 300;
  localparam int DEF_BTN_X1 = 499;
  localparam int DEF_BTN_Y0 = 250;
  localparam int DEF_BTN_Y1 = 349;
  localparam int CLICK_HOLD = 30;
  function automatic logic in_range(input logic [12:0] v, input logic [12:0] lo, input logic [12:0] hi);
    return v >= lo && v <= hi;
  endfunction
endpackage

// File: rtl/game_ctl_edge_sync.sv
// edge_sync: optional 2-flop synchronizer followed by a registered rising-edge pulse.
module edge_sync #(
  parameter bit SYNC = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);
  logic [1:0] sync_q, sync_d;
  logic prev_q, prev_d, pulse_q, pulse_d, lvl;
  assign lvl = SYNC ? sync_q[1] : sig;
  always_comb begin
    sync_d  = {sync_q[0], sig};
    prev_d  = lvl;
    pulse_d = lvl & ~prev_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end
  assign pulse = pulse_q;
endmodule

// File: rtl/game_ctl.sv
// game_ctl: start/play/over sequencer with click scoring, frame-based round timer and tear-free screen select.
module game_ctl
  import game_ctl_pkg::*;
#(
  parameter int BTN_X0         = DEF_BTN_X0,
  parameter int BTN_X1         = DEF_BTN_X1,
  parameter int BTN_Y0         = DEF_BTN_Y0,
  parameter int BTN_Y1         = DEF_BTN_Y1,
  parameter int BUG_W          = 64,
  parameter int BUG_H          = 64,
  parameter int GAME_SECONDS   = 30,
  parameter int FRAMES_PER_SEC = 60,
  parameter int OVER_FRAMES    = 180
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        mouse_left,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [11:0] x_bugpos,
  input  logic [11:0] y_bugpos,
  output logic [1:0]  screen_sel,
  output logic        bug_rst,
  output logic [7:0]  score,
  output logic [7:0]  time_left,
  output logic        playing
);
  logic click, frame_tick, on_btn, on_bug;
  state_e state_q, state_d;
  logic go_q, go_d, bug_rst_q, bug_rst_d;
  logic [7:0] score_q, score_d, time_q, time_d, frame_q, frame_d, hold_q, hold_d;
  logic [1:0] sel_q, sel_d;
  edge_sync #(.SYNC(1'b1)) u_mouse (.clk(pclk), .rst(rst), .sig(mouse_left), .pulse(click));
  // vblnk is already in the pclk domain, so only the edge detector is kept to meet the 1-cycle tick latency
  edge_sync #(.SYNC(1'b0)) u_vblnk (.clk(pclk), .rst(rst), .sig(vblnk), .pulse(frame_tick));
  assign on_btn = in_range(13'(xpos), 13'(BTN_X0), 13'(BTN_X1)) && in_range(13'(ypos), 13'(BTN_Y0), 13'(BTN_Y1));
  assign on_bug = in_range(13'(xpos), 13'(x_bugpos), 13'(x_bugpos) + 13'(BUG_W - 1))
               && in_range(13'(ypos), 13'(y_bugpos), 13'(y_bugpos) + 13'(BUG_H - 1));
  always_comb begin
    state_d   = state_q;
    go_d      = go_q;
    score_d   = score_q;
    time_d    = time_q;
    frame_d   = frame_q;
    hold_d    = hold_q;
    bug_rst_d = 1'b0;
    case (state_q)
      ST_START: begin
        if (click && on_btn) go_d = 1'b1;
        if (frame_tick && go_q) begin
          state_d   = ST_PLAY;
          go_d      = 1'b0;
          score_d   = '0;
          time_d    = 8'(GAME_SECONDS);
          frame_d   = '0;
          bug_rst_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (click && on_bug) begin
          score_d   = score_q == 8'hff ? score_q : score_q + 8'd1;
          bug_rst_d = 1'b1;
        end
        if (frame_tick) begin
          frame_d = frame_q == 8'(FRAMES_PER_SEC - 1) ? 8'd0 : frame_q + 8'd1;
          if (frame_q == 8'(FRAMES_PER_SEC - 1)) begin
            time_d = time_q - 8'd1;
            if (time_q == 8'd1) begin
              state_d = ST_OVER;
              hold_d  = '0;
            end
          end
        end
      end
      ST_OVER: begin
        hold_d  = frame_tick ? hold_q + 8'd1 : hold_q;
        state_d = (hold_d == 8'(OVER_FRAMES) || (click && hold_q >= 8'(CLICK_HOLD))) ? ST_START : ST_OVER;
      end
      default: state_d = ST_START;
    endcase
    sel_d = frame_tick ? state_d : sel_q;
  end
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_START;
      go_q      <= 1'b0;
      score_q   <= '0;
      time_q    <= 8'(GAME_SECONDS);
      frame_q   <= '0;
      hold_q    <= '0;
      bug_rst_q <= 1'b0;
      sel_q     <= ST_START;
    end else begin
      state_q   <= state_d;
      go_q      <= go_d;
      score_q   <= score_d;
      time_q    <= time_d;
      frame_q   <= frame_d;
      hold_q    <= hold_d;
      bug_rst_q <= bug_rst_d;
      sel_q     <= sel_d;
    end
  end
  assign screen_sel = sel_q;
  assign bug_rst    = bug_rst_q;
  assign score      = score_q;
  assign time_left  = time_q;
  assign playing    = state_q == ST_PLAY;
endmodule

// File: tb/tb_game_ctl.sv
// tb_game_ctl: directed stimulus for game_ctl checked against a tick-counting game model every cycle.
module tb_game_ctl;
  logic clk = 1'b0, rst = 1'b1, vblnk = 1'b0, mouse_left = 1'b0;
  logic [11:0] xpos = '0, ypos = '0, x_bugpos = 12'd200, y_bugpos = 12'd200;
  logic [1:0] screen_sel;
  logic bug_rst, playing;
  logic [7:0] score, time_left;
  int total = 0, bad = 0;
  int m_phase = 0, m_pend = 0, m_score = 0, m_played = 0, m_hold = 0, m_bug = 0, m_sel = 0;
  logic [3:0] mh = '0, vh = '0;
  game_ctl dut (
    .pclk(clk), .rst(rst), .vblnk(vblnk), .mouse_left(mouse_left),
    .xpos(xpos), .ypos(ypos), .x_bugpos(x_bugpos), .y_bugpos(y_bugpos),
    .screen_sel(screen_sel), .bug_rst(bug_rst), .score(score),
    .time_left(time_left), .playing(playing)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask
  // Game model: the round is a count of frame ticks, time_left is derived from it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_pend = 0; m_score = 0; m_played = 0; m_hold = 0; m_bug = 0; m_sel = 0;
      mh = '0; vh = '0;
    end else begin
      automatic bit clk_ev = mh[2] && !mh[3];
      automatic bit tick = vh[0] && !vh[1];
      automatic int x = int'(xpos), y = int'(ypos), bx = int'(x_bugpos), by = int'(y_bugpos);
      automatic int hold_old = m_hold;
      m_bug = 0;
      if (m_phase == 0) begin
        automatic bit go = tick && m_pend != 0;
        if (clk_ev && x >= 300 && x <= 499 && y >= 250 && y <= 349) m_pend = 1;
        if (go) begin
          m_phase = 1; m_pend = 0; m_score = 0; m_played = 0; m_bug = 1;
        end
      end else if (m_phase == 1) begin
        if (clk_ev && x >= bx && x < bx + 64 && y >= by && y < by + 64) begin
          m_score = m_score < 255 ? m_score + 1 : 255;
          m_bug = 1;
        end
        if (tick) m_played++;
        if (m_played == 1800) begin
          m_phase = 2; m_hold = 0;
        end
      end else begin
        if (tick) m_hold++;
        if (m_hold == 180 || (clk_ev && hold_old >= 30)) m_phase = 0;
      end
      if (tick) m_sel = m_phase;
      mh = {mh[2:0], mouse_left};
      vh = {vh[2:0], vblnk};
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("screen_sel", int'(screen_sel), m_sel);
      chk("bug_rst", int'(bug_rst), m_bug);
      chk("score", int'(score), m_score);
      chk("time_left", int'(time_left), 30 - m_played / 60);
      chk("playing", int'(playing), int'(m_phase == 1));
    end
  end
  task automatic frame();
    vblnk = 1'b1;
    repeat (2) @(negedge clk);
    vblnk = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic click_at(input int x, input int y);
    xpos = 12'(x); ypos = 12'(y);
    mouse_left = 1'b1;
    repeat (2) @(negedge clk);
    mouse_left = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  // Click whose synchronized pulse lands on the same edge as a frame tick.
  task automatic click_tick(input int x, input int y);
    xpos = 12'(x); ypos = 12'(y);
    mouse_left = 1'b1;
    repeat (2) @(negedge clk);
    vblnk = 1'b1;
    @(negedge clk);
    mouse_left = 1'b0;
    @(negedge clk);
    vblnk = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_sel", int'(screen_sel), 0);
    chk("rst_time", int'(time_left), 30);
    chk("rst_score", int'(score), 0);
    chk("rst_bug", int'(bug_rst), 0);
    chk("rst_playing", int'(playing), 0);
    repeat (3) frame();
    chk("idle_sel", int'(screen_sel), 0);
    chk("idle_time", int'(time_left), 30);
    click_at(100, 100);
    frame();
    chk("off_button_sel", int'(screen_sel), 0);
    click_at(400, 300);
    frame();
    chk("start_sel", int'(screen_sel), 1);
    chk("start_score", int'(score), 0);
    chk("start_playing", int'(playing), 1);
    click_at(230, 230);
    chk("hit_score", int'(score), 1);
    click_at(264, 230);
    chk("x_edge_score", int'(score), 1);
    click_at(230, 264);
    chk("y_edge_score", int'(score), 1);
    click_at(199, 230);
    chk("left_miss_score", int'(score), 1);
    click_at(263, 263);
    chk("corner_score", int'(score), 2);
    repeat (256) click_at(230, 230);
    chk("sat_score", int'(score), 255);
    repeat (60) frame();
    chk("time_29", int'(time_left), 29);
    repeat (1739) frame();
    chk("time_1", int'(time_left), 1);
    chk("time_1_sel", int'(screen_sel), 1);
    frame();
    chk("over_time", int'(time_left), 0);
    chk("over_sel", int'(screen_sel), 2);
    chk("over_playing", int'(playing), 0);
    chk("over_score_held", int'(score), 255);
    repeat (179) frame();
    chk("hold_179_sel", int'(screen_sel), 2);
    frame();
    chk("hold_180_sel", int'(screen_sel), 0);
    click_tick(400, 300);
    chk("coincide_sel", int'(screen_sel), 0);
    frame();
    chk("round2_sel", int'(screen_sel), 1);
    repeat (5) click_at(230, 230);
    chk("round2_score", int'(score), 5);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sel", int'(screen_sel), 0);
    chk("midrst_score", int'(score), 0);
    chk("midrst_time", int'(time_left), 30);
    chk("midrst_playing", int'(playing), 0);
    chk("midrst_bug", int'(bug_rst), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    click_at(400, 300);
    frame();
    chk("round3_sel", int'(screen_sel), 1);
    repeat (1799) frame();
    chk("round3_time_1", int'(time_left), 1);
    click_tick(230, 230);
    chk("final_hit_score", int'(score), 1);
    chk("final_hit_sel", int'(screen_sel), 2);
    chk("final_hit_time", int'(time_left), 0);
    repeat (10) frame();
    click_at(400, 300);
    frame();
    chk("early_click_sel", int'(screen_sel), 2);
    repeat (20) frame();
    click_at(10, 10);
    frame();
    chk("late_click_sel", int'(screen_sel), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
